branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Next-PC predictor for the TSC pipeline; the source of the i_branch_miss/jump_miss flush requests
//  consumed by hazard control. IF looks up a direct-mapped BTB with 2-bit counters to pick the next PC.
//  EX/ID resolution compares the actual outcome against the PC that was predicted.
//  On a mismatch it raises the miss flag and correct_pc; the table trains on the same clock edge.
// PARAMETERS
//  IDX_BITS   8    BTB index width; 2**IDX_BITS entries, index = pc[IDX_BITS-1:0], tag = pc[15:IDX_BITS]
//  WORD       16   PC/target width
// PORTS
//  clk               in   1     clock
//  reset             in   1     synchronous, active-high reset
//  pc_IF             in   WORD  PC being fetched
//  predicted_pc      out  WORD  next fetch PC (combinational)
//  pred_taken_IF     out  1     1 = predicted_pc came from the BTB target
//  ready             out  1     1 = table initialised, predictions enabled
//  upd_valid         in   1     resolution info valid this cycle
//  upd_is_branch     in   1     resolved instr is BNE/BEQ/BGZ/BLZ
//  upd_is_jump       in   1     resolved instr is JMP/JAL/JPR/JRL
//  upd_pc            in   WORD  PC of resolved instr
//  upd_taken         in   1     actual direction (ignored for jumps; treated as 1)
//  upd_target        in   WORD  actual target
//  upd_pred_pc       in   WORD  next PC that was predicted for this instr
//  i_branch_miss     out  1     conditional-branch mispredict (combinational)
//  jump_miss         out  1     jump mispredict (combinational)
//  correct_pc        out  WORD  actual next PC (combinational)
//  branch_count      out  16    resolved branch+jump count, saturating
//  miss_count        out  16    mispredict count, saturating
// BEHAVIOUR
//  Entry fields: valid, tag, target[WORD], is_jump, ctr[1:0]. Storage is a register array.
//  FSM INIT->RUN:
//   - reset puts the block in INIT with clr_idx=0, ready=0, branch_count=miss_count=0.
//   - INIT clears valid[clr_idx] each cycle and increments clr_idx.
//   - At clr_idx = 2**IDX_BITS-1, that entry is cleared and the block moves to RUN next cycle.
//   - INIT therefore lasts exactly 2**IDX_BITS cycles.
//   - reset asserted in RUN or mid-INIT restarts INIT at index 0.
//  Prediction:
//   - hit = ready & valid & tag match.
//   - pred_taken_IF = hit & (is_jump | ctr[1]).
//   - predicted_pc = pred_taken_IF ? target : pc_IF+1, with WORD-bit wrap (0xFFFF+1 = 0x0000).
//   - While INIT, hit=0.
//  Resolution, combinational, valid in INIT and RUN:
//   - actual = (upd_is_jump | upd_taken) ? upd_target : upd_pc+1.
//   - mis = upd_valid & (upd_pred_pc != actual).
//   - i_branch_miss = mis & upd_is_branch & ~upd_is_jump.
//   - jump_miss = mis & upd_is_jump.
//   - correct_pc = actual.
//   - If both is_branch and is_jump are set, is_jump wins. If neither is set, no miss and no training.
//  Training on the posedge, RUN only; ignored in INIT:
//   - Branch hit: ctr saturating +1 if taken, -1 if not (3 and 0 hold). Target is rewritten when taken.
//   - Branch miss in BTB, taken: allocate/overwrite the entry with tag, target, is_jump=0, ctr=2'b10.
//   - Branch miss in BTB, not taken: no change.
//   - Jump: allocate/overwrite the entry with is_jump=1, ctr=2'b11, target=upd_target.
//  Same-cycle lookup and update to one index: the lookup sees the pre-update entry; the new value is visible next cycle.
//  Counters: on each posedge with upd_valid & (is_branch|is_jump), branch_count++ and miss_count += mis.
//   Both counters saturate at 0xFFFF, and both count during INIT as well.
//  Reset values:
//   - predicted_pc = pc_IF+1, pred_taken_IF=0, ready=0.
//   - Misses depend only on upd_* inputs.
//   - Counters are 0.
// TESTING
//  Init: reset 1 cycle, IDX_BITS=8 -> ready rises exactly 256 cycles after reset drop.
//   During INIT, pc_IF=0x0040 -> predicted_pc=0x0041.
//  Cold branch: upd BEQ pc=0x0010 taken, target=0x0030, pred_pc=0x0011 -> i_branch_miss=1, correct_pc=0x0030.
//   Next cycle pc_IF=0x0010 -> predicted_pc=0x0030, pred_taken_IF=1.
//  Counter hysteresis: from ctr=2, one not-taken resolve -> ctr=1, predicted_pc=0x0011.
//   Two taken -> ctr=3. One not-taken -> ctr=2, still taken.
//  Jump: JMP pc=0x0100, target=0x0200, pred_pc=0x0101 -> jump_miss=1, i_branch_miss=0.
//   Repeat with pred_pc=0x0200 -> no miss.
//  Aliasing: entry at 0x0010, lookup 0x0110 (same index, different tag) -> predicted_pc=0x0111.
//   Same-cycle update to 0x0010 while looking up 0x0010 -> old prediction shown that cycle.
//  Reset mid-RUN: populated BTB, assert reset -> ready=0, counters=0, all lookups miss after the re-INIT.
//   Also check counter saturation at 0xFFFF.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and resolution-side update bundle for the BTB next-PC predictor.
// The pipeline/testbench drives the master side; the predictor is the slave.
interface branch_predictor_if #(
  parameter int unsigned WORD = 16
);
  logic [WORD-1:0] pc_IF;
  logic [WORD-1:0] predicted_pc;
  logic            pred_taken_IF;
  logic            ready;
  logic            upd_valid;
  logic            upd_is_branch;
  logic            upd_is_jump;
  logic [WORD-1:0] upd_pc;
  logic            upd_taken;
  logic [WORD-1:0] upd_target;
  logic [WORD-1:0] upd_pred_pc;
  logic            i_branch_miss;
  logic            jump_miss;
  logic [WORD-1:0] correct_pc;
  logic [15:0]     branch_count;
  logic [15:0]     miss_count;

  modport master (
    output pc_IF, upd_valid, upd_is_branch, upd_is_jump, upd_pc,
           upd_taken, upd_target, upd_pred_pc,
    input  predicted_pc, pred_taken_IF, ready, i_branch_miss, jump_miss,
           correct_pc, branch_count, miss_count
  );

  modport slave (
    input  pc_IF, upd_valid, upd_is_branch, upd_is_jump, upd_pc,
           upd_taken, upd_target, upd_pred_pc,
    output predicted_pc, pred_taken_IF, ready, i_branch_miss, jump_miss,
           correct_pc, branch_count, miss_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB next-PC predictor with 2-bit counters; flags branch/jump
// mispredicts at resolution and trains the table on the same clock edge.
module branch_predictor #(
  parameter int unsigned IDX_BITS = 8,
  parameter int unsigned WORD     = 16
) (
  input logic          clk,
  input logic          reset,
  branch_predictor_if.slave bus
);
  localparam int unsigned ENTRIES  = 2 ** IDX_BITS;
  localparam int unsigned TAG_BITS = WORD - IDX_BITS;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state;
  logic [IDX_BITS-1:0] clr_idx;
  logic                ready_q;
  logic [15:0]         branch_cnt;
  logic [15:0]         miss_cnt;

  logic                valid_q   [ENTRIES];
  logic [TAG_BITS-1:0] tag_q     [ENTRIES];
  logic [WORD-1:0]     target_q  [ENTRIES];
  logic                is_jump_q [ENTRIES];
  logic [1:0]          ctr_q     [ENTRIES];

  logic [IDX_BITS-1:0] rd_idx;
  logic [TAG_BITS-1:0] rd_tag;
  logic                rd_hit;
  logic                rd_taken;

  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  logic                upd_hit;
  logic                upd_ctl;
  logic [WORD-1:0]     actual_pc;
  logic                mis;

  assign rd_idx  = bus.pc_IF[IDX_BITS-1:0];
  assign rd_tag  = bus.pc_IF[WORD-1:IDX_BITS];
  assign upd_idx = bus.upd_pc[IDX_BITS-1:0];
  assign upd_tag = bus.upd_pc[WORD-1:IDX_BITS];

  // Lookup reads the registered table, so a same-cycle update is seen only next cycle.
  always_comb begin
    rd_hit   = ready_q & valid_q[rd_idx] & (tag_q[rd_idx] == rd_tag);
    rd_taken = rd_hit & (is_jump_q[rd_idx] | ctr_q[rd_idx][1]);
  end

  assign bus.pred_taken_IF = rd_taken;
  assign bus.predicted_pc  = rd_taken ? target_q[rd_idx] : bus.pc_IF + WORD'(1);
  assign bus.ready         = ready_q;

  always_comb begin
    upd_ctl   = bus.upd_is_branch | bus.upd_is_jump;
    actual_pc = (bus.upd_is_jump | bus.upd_taken) ? bus.upd_target
                                                  : bus.upd_pc + WORD'(1);
    mis       = bus.upd_valid & (bus.upd_pred_pc != actual_pc);
    upd_hit   = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
  end

  assign bus.i_branch_miss = mis & bus.upd_is_branch & ~bus.upd_is_jump;
  assign bus.jump_miss     = mis & bus.upd_is_jump;
  assign bus.correct_pc    = actual_pc;
  assign bus.branch_count  = branch_cnt;
  assign bus.miss_count    = miss_cnt;

  // Table arrays carry no reset; INIT walks every entry and clears its valid bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      clr_idx    <= '0;
      ready_q    <= 1'b0;
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      if (bus.upd_valid && upd_ctl) begin
        if (branch_cnt != '1) branch_cnt <= branch_cnt + 16'd1;
        if (mis && (miss_cnt != '1)) miss_cnt <= miss_cnt + 16'd1;
      end

      case (state)
        INIT: begin
          valid_q[clr_idx] <= 1'b0;
          clr_idx          <= clr_idx + 1'b1;
          if (clr_idx == '1) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end

        RUN: begin
          if (bus.upd_valid && upd_ctl) begin
            if (bus.upd_is_jump) begin
              valid_q[upd_idx]   <= 1'b1;
              tag_q[upd_idx]     <= upd_tag;
              target_q[upd_idx]  <= bus.upd_target;
              is_jump_q[upd_idx] <= 1'b1;
              ctr_q[upd_idx]     <= 2'b11;
            end else if (upd_hit) begin
              if (bus.upd_taken) begin
                target_q[upd_idx] <= bus.upd_target;
                if (ctr_q[upd_idx] != 2'b11) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'b01;
              end else begin
                if (ctr_q[upd_idx] != 2'b00) ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'b01;
              end
            end else if (bus.upd_taken) begin
              valid_q[upd_idx]   <= 1'b1;
              tag_q[upd_idx]     <= upd_tag;
              target_q[upd_idx]  <= bus.upd_target;
              is_jump_q[upd_idx] <= 1'b0;
              ctr_q[upd_idx]     <= 2'b10;
            end
          end
        end

        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expected values are queued as stimulus
// is applied and popped when the corresponding DUT output is sampled.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predictor_if #(.WORD(16)) bus ();

  branch_predictor #(.IDX_BITS(8), .WORD(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_upd(input logic v, input logic br, input logic jmp,
                           input logic [15:0] pc, input logic tk,
                           input logic [15:0] tgt, input logic [15:0] pred);
    bus.upd_valid     = v;
    bus.upd_is_branch = br;
    bus.upd_is_jump   = jmp;
    bus.upd_pc        = pc;
    bus.upd_taken     = tk;
    bus.upd_target    = tgt;
    bus.upd_pred_pc   = pred;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.ready && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    drive_upd(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    bus.pc_IF = 16'h0040;
    reset = 1'b1;
    tick();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0041);
    exp_v = exp_q.pop_front(); checks++;
    if (16'(bus.ready) !== exp_v) begin failures++; $display("FAIL reset_ready got=%h exp=%h", bus.ready, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (bus.branch_count !== exp_v) begin failures++; $display("FAIL reset_branch_count got=%h exp=%h", bus.branch_count, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (bus.miss_count !== exp_v) begin failures++; $display("FAIL reset_miss_count got=%h exp=%h", bus.miss_count, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (bus.predicted_pc !== exp_v) begin failures++; $display("FAIL reset_predicted_pc got=%h exp=%h", bus.predicted_pc, exp_v); end
    reset = 1'b0;
  endtask

  task automatic test_init();
    int n;
    n = 0;
    while (!bus.ready && n < 1000) begin
      tick();
      n++;
      if (n == 100) begin
        exp_q.push_back(16'h0041);
        exp_v = exp_q.pop_front(); checks++;
        if (bus.predicted_pc !== exp_v) begin failures++; $display("FAIL init_predicted_pc got=%h exp=%h", bus.predicted_pc, exp_v); end
      end
    end
    exp_q.push_back(16'd256);
    exp_v = exp_q.pop_front(); checks++;
    if (16'(n) !== exp_v) begin failures++; $display("FAIL init_cycles got=%0d exp=%0d", n, exp_v); end
  endtask

  task automatic test_cold_branch();
    drive_upd(1'b1, 1'b1, 1'b0, 16'h0010, 1'b1, 16'h0030, 16'h0011);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0030);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (16'(bus.i_branch_miss) !== exp_v) begin failures++; $display("FAIL cold_branch_miss got=%h exp=%h", bus.i_branch_miss, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (16'(bus.jump_miss) !== exp_v) begin failures++; $display("FAIL cold_jump_miss got=%h exp=%h", bus.jump_miss, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (bus.correct_pc !== exp_v) begin failures++; $display("FAIL cold_correct_pc got=%h exp=%h", bus.correct_pc, exp_v); end
    tick();
    drive_upd(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    bus.pc_IF = 16'h0010;
    exp_q.push_back(16'h0030);
    exp_q.push_back(16'h0001);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.predicted_pc !== exp_v) begin failures++; $display("FAIL cold_predicted_pc got=%h exp=%h", bus.predicted_pc, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (16'(bus.pred_taken_IF) !== exp_v) begin failures++; $display("FAIL cold_pred_taken got=%h exp=%h", bus.pred_taken_IF, exp_v); end
  endtask

  task automatic test_hysteresis();
    // ctr 2 -> 1 (not taken) -> 2 -> 3 (taken, taken) -> 2 (not taken, still predicts taken)
    bus.pc_IF = 16'h0010;
    drive_upd(1'b1, 1'b1, 1'b0, 16'h0010, 1'b0, 16'h0030, 16'h0030);
    tick();
    drive_upd(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    exp_q.push_back(16'h0011);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.predicted_pc !== exp_v) begin failures++; $display("FAIL hyst_ctr1_pc got=%h exp=%h", bus.predicted_pc, exp_v); end
    drive_upd(1'b1, 1'b1, 1'b0, 16'h0010, 1'b1, 16'h0030, 16'h0011);
    tick();
    drive_upd(1'b1, 1'b1, 1'b0, 16'h0010, 1'b1, 16'h0030, 16'h0030);
    exp_q.push_back(16'h0000);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (16'(bus.i_branch_miss) !== exp_v) begin failures++; $display("FAIL hyst_correct_pred_miss got=%h exp=%h", bus.i_branch_miss, exp_v); end
    tick();
    drive_upd(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    exp_q.push_back(16'h0030);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.predicted_pc !== exp_v) begin failures++; $display("FAIL hyst_ctr3_pc got=%h exp=%h", bus.predicted_pc, exp_v); end
    drive_upd(1'b1, 1'b1, 1'b0, 16'h0010, 1'b0, 16'h0030, 16'h0030);
    tick();
    drive_upd(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    exp_q.push_back(16'h0030);
    exp_q.push_back(16'h0001);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.predicted_pc !== exp_v) begin failures++; $display("FAIL hyst_ctr2_pc got=%h exp=%h", bus.predicted_pc, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (16'(bus.pred_taken_IF) !== exp_v) begin failures++; $display("FAIL hyst_ctr2_taken got=%h exp=%h", bus.pred_taken_IF, exp_v); end
  endtask

  task automatic test_jump();
    drive_upd(1'b1, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0200, 16'h0101);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0200);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (16'(bus.jump_miss) !== exp_v) begin failures++; $display("FAIL jump_miss got=%h exp=%h", bus.jump_miss, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (16'(bus.i_branch_miss) !== exp_v) begin failures++; $display("FAIL jump_branch_miss got=%h exp=%h", bus.i_branch_miss, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (bus.correct_pc !== exp_v) begin failures++; $display("FAIL jump_correct_pc got=%h exp=%h", bus.correct_pc, exp_v); end
    tick();
    // both type flags set: jump semantics apply, correct prediction
    drive_upd(1'b1, 1'b1, 1'b1, 16'h0100, 1'b0, 16'h0200, 16'h0200);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (16'(bus.jump_miss) !== exp_v) begin failures++; $display("FAIL jump_repeat_miss got=%h exp=%h", bus.jump_miss, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (16'(bus.i_branch_miss) !== exp_v) begin failures++; $display("FAIL jump_repeat_branch_miss got=%h exp=%h", bus.i_branch_miss, exp_v); end
    tick();
    drive_upd(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    bus.pc_IF = 16'h0100;
    exp_q.push_back(16'h0200);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.predicted_pc !== exp_v) begin failures++; $display("FAIL jump_predicted_pc got=%h exp=%h", bus.predicted_pc, exp_v); end
  endtask

  task automatic test_aliasing();
    bus.pc_IF = 16'h0110;
    exp_q.push_back(16'h0111);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.predicted_pc !== exp_v) begin failures++; $display("FAIL alias_predicted_pc got=%h exp=%h", bus.predicted_pc, exp_v); end
    // same-cycle lookup/update at 0x0010: ctr 2 -> 1, old prediction visible now
    bus.pc_IF = 16'h0010;
    drive_upd(1'b1, 1'b1, 1'b0, 16'h0010, 1'b0, 16'h0030, 16'h0030);
    exp_q.push_back(16'h0030);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.predicted_pc !== exp_v) begin failures++; $display("FAIL same_cycle_old_pc got=%h exp=%h", bus.predicted_pc, exp_v); end
    tick();
    drive_upd(1'b1, 1'b0, 1'b0, 16'h0500, 1'b1, 16'h0777, 16'h1234);
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.predicted_pc !== exp_v) begin failures++; $display("FAIL same_cycle_new_pc got=%h exp=%h", bus.predicted_pc, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (16'(bus.i_branch_miss) !== exp_v) begin failures++; $display("FAIL untyped_branch_miss got=%h exp=%h", bus.i_branch_miss, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (16'(bus.jump_miss) !== exp_v) begin failures++; $display("FAIL untyped_jump_miss got=%h exp=%h", bus.jump_miss, exp_v); end
    tick();
    drive_upd(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    exp_q.push_back(16'd8);
    exp_q.push_back(16'd6);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.branch_count !== exp_v) begin failures++; $display("FAIL run_branch_count got=%0d exp=%0d", bus.branch_count, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (bus.miss_count !== exp_v) begin failures++; $display("FAIL run_miss_count got=%0d exp=%0d", bus.miss_count, exp_v); end
  endtask

  task automatic test_reset_midrun();
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_v = exp_q.pop_front(); checks++;
    if (16'(bus.ready) !== exp_v) begin failures++; $display("FAIL midrun_ready got=%h exp=%h", bus.ready, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (bus.branch_count !== exp_v) begin failures++; $display("FAIL midrun_branch_count got=%h exp=%h", bus.branch_count, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (bus.miss_count !== exp_v) begin failures++; $display("FAIL midrun_miss_count got=%h exp=%h", bus.miss_count, exp_v); end
    wait_ready(n);
    exp_q.push_back(16'd256);
    exp_v = exp_q.pop_front(); checks++;
    if (16'(n) !== exp_v) begin failures++; $display("FAIL reinit_cycles got=%0d exp=%0d", n, exp_v); end
    bus.pc_IF = 16'h0010;
    exp_q.push_back(16'h0011);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.predicted_pc !== exp_v) begin failures++; $display("FAIL reinit_lookup_0010 got=%h exp=%h", bus.predicted_pc, exp_v); end
    bus.pc_IF = 16'h0100;
    exp_q.push_back(16'h0101);
    exp_q.push_back(16'h0000);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.predicted_pc !== exp_v) begin failures++; $display("FAIL reinit_lookup_0100 got=%h exp=%h", bus.predicted_pc, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (16'(bus.pred_taken_IF) !== exp_v) begin failures++; $display("FAIL reinit_taken_0100 got=%h exp=%h", bus.pred_taken_IF, exp_v); end
  endtask

  task automatic test_saturation();
    bus.pc_IF = 16'hFFFF;
    exp_q.push_back(16'h0000);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.predicted_pc !== exp_v) begin failures++; $display("FAIL wrap_predicted_pc got=%h exp=%h", bus.predicted_pc, exp_v); end
    drive_upd(1'b1, 1'b1, 1'b0, 16'h0020, 1'b1, 16'h0050, 16'h0000);
    for (int i = 0; i < 65535; i++) tick();
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'hFFFF);
    exp_v = exp_q.pop_front(); checks++;
    if (bus.branch_count !== exp_v) begin failures++; $display("FAIL sat_branch_count got=%h exp=%h", bus.branch_count, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (bus.miss_count !== exp_v) begin failures++; $display("FAIL sat_miss_count got=%h exp=%h", bus.miss_count, exp_v); end
    tick();
    tick();
    drive_upd(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'hFFFF);
    exp_v = exp_q.pop_front(); checks++;
    if (bus.branch_count !== exp_v) begin failures++; $display("FAIL sat_hold_branch_count got=%h exp=%h", bus.branch_count, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (bus.miss_count !== exp_v) begin failures++; $display("FAIL sat_hold_miss_count got=%h exp=%h", bus.miss_count, exp_v); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_cold_branch();
    test_hysteresis();
    test_jump();
    test_aliasing();
    test_reset_midrun();
    test_saturation();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
